// File: rtl/clock_divider_mc_pkg.sv
// Shared defaults and helpers for the multi-channel clock divider.
package clkdiv_pkg;

  localparam int unsigned CH_DEFAULT = 4;
  localparam int unsigned W_DEFAULT  = 4;

  // Length of the high phase for ratio r; odd ratios get the extra cycle high.
  function automatic int unsigned ceil_half(input int unsigned r);
    return r - (r >> 1);
  endfunction

endpackage

// File: rtl/clock_divider_mc_if.sv
// Control/status bundle between the divider and its consumer.
interface clock_divider_mc_if
  import clkdiv_pkg::*;
#(
  parameter int unsigned CH = CH_DEFAULT,
  parameter int unsigned W  = W_DEFAULT
);

  logic [CH-1:0]   en_i;
  logic            sync_i;
  logic [CH*W-1:0] div_i;
  logic [CH-1:0]   clk_o;
  logic [CH-1:0]   tick_o;

  modport master (
    output en_i,
    output sync_i,
    output div_i,
    input  clk_o,
    input  tick_o
  );

  modport slave (
    input  en_i,
    input  sync_i,
    input  div_i,
    output clk_o,
    output tick_o
  );

endinterface

// File: rtl/clock_divider_mc_ch.sv
// One divider channel: enable state, period counter, active divisor and
// registered clk/tick decode.
module clock_divider_ch
  import clkdiv_pkg::*;
#(
  parameter int unsigned W = W_DEFAULT
) (
  input  logic         clk_i,
  input  logic         rst,
  input  logic         en_i,
  input  logic         sync_i,
  input  logic [W-1:0] div_i,
  output logic         clk_o,
  output logic         tick_o
);

  typedef enum logic {
    CH_IDLE = 1'b0,
    CH_RUN  = 1'b1
  } ch_state_t;

  ch_state_t    state_q, state_d;
  logic [W-1:0] cnt_q, cnt_d;
  logic [W-1:0] div_q, div_d;
  logic         clk_d, tick_d;
  logic         terminal;

  assign terminal = (cnt_q == div_q);

  always_ff @(posedge clk_i or posedge rst) begin
    if (rst) begin
      state_q <= CH_IDLE;
      cnt_q   <= '0;
      div_q   <= '0;
      clk_o   <= 1'b0;
      tick_o  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      div_q   <= div_d;
      clk_o   <= clk_d;
      tick_o  <= tick_d;
    end
  end

  always_comb begin
    state_d = en_i ? CH_RUN : CH_IDLE;
  end

  // Every load point (disabled, fresh enable, sync, wrap) restarts the
  // period with the divisor currently presented, so no runt pulse appears.
  always_comb begin
    cnt_d = '0;
    div_d = div_q;
    if (!en_i || sync_i || (state_q == CH_IDLE) || terminal) begin
      cnt_d = '0;
      div_d = div_i;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // Outputs are decoded from next-state so they line up with the new count.
  always_comb begin
    clk_d  = 1'b0;
    tick_d = 1'b0;
    if (state_d == CH_RUN) begin
      clk_d  = (32'(cnt_d) < ceil_half(32'(div_d) + 32'd1));
      tick_d = (cnt_d == div_d);
    end
  end

endmodule

// File: rtl/clock_divider_mc.sv
// Multi-channel programmable clock divider: CH independent channels sharing
// one phase-sync strobe.
module clock_divider_mc
  import clkdiv_pkg::*;
#(
  parameter int unsigned CH = CH_DEFAULT,
  parameter int unsigned W  = W_DEFAULT
) (
  input logic               clk_i,
  input logic               rst,
  clock_divider_mc_if.slave bus
);

  logic [CH-1:0] clk_v;
  logic [CH-1:0] tick_v;

  for (genvar n = 0; n < CH; n++) begin : g_ch
    clock_divider_ch #(
      .W(W)
    ) u_ch (
      .clk_i  (clk_i),
      .rst    (rst),
      .en_i   (bus.en_i[n]),
      .sync_i (bus.sync_i),
      .div_i  (bus.div_i[n*W +: W]),
      .clk_o  (clk_v[n]),
      .tick_o (tick_v[n])
    );
  end

  assign bus.clk_o  = clk_v;
  assign bus.tick_o = tick_v;

endmodule

// File: tb/tb_clock_divider_mc.sv
// Directed bench for clock_divider_mc with two 4-bit channels.
module tb_clock_divider_mc;

  logic clk;
  logic rst;
  int unsigned total;
  int unsigned passed;

  clock_divider_mc_if #(.CH(2), .W(4)) bus ();

  clock_divider_mc #(
    .CH(2),
    .W (4)
  ) dut (
    .clk_i (clk),
    .rst   (rst),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", tag, act, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Patterns are MSB-first: bit n-1 is the first cycle checked.
  task automatic run_cycles(input string tag, input int n,
                            input logic [31:0] e_clk0, input logic [31:0] e_tick0,
                            input logic [31:0] e_clk1, input logic [31:0] e_tick1);
    for (int i = 0; i < n; i++) begin
      int idx;
      idx = n - 1 - i;
      step();
      check($sformatf("%s clk0[%0d]", tag, i),  32'(bus.clk_o[0]),  32'(e_clk0[idx]));
      check($sformatf("%s tick0[%0d]", tag, i), 32'(bus.tick_o[0]), 32'(e_tick0[idx]));
      check($sformatf("%s clk1[%0d]", tag, i),  32'(bus.clk_o[1]),  32'(e_clk1[idx]));
      check($sformatf("%s tick1[%0d]", tag, i), 32'(bus.tick_o[1]), 32'(e_tick1[idx]));
    end
  endtask

  initial begin
    total      = 0;
    passed     = 0;
    rst        = 1'b1;
    bus.en_i   = 2'b00;
    bus.sync_i = 1'b0;
    bus.div_i  = 8'h23;   // ch1 div=2, ch0 div=3

    #1;
    check("rst_async clk", 32'(bus.clk_o), 32'd0);
    check("rst_async tick", 32'(bus.tick_o), 32'd0);
    step();
    step();
    check("rst clk", 32'(bus.clk_o), 32'd0);
    check("rst tick", 32'(bus.tick_o), 32'd0);

    rst = 1'b0;
    step();
    check("idle clk", 32'(bus.clk_o), 32'd0);
    check("idle tick", 32'(bus.tick_o), 32'd0);

    // Enable both: ch0 R=4 -> 1100, ch1 R=3 -> 110, outputs start on the enable edge.
    bus.en_i = 2'b11;
    run_cycles("en", 12, 32'hCCC, 32'h111, 32'hDB6, 32'h249);

    // Change ch0 to div=5 while at cnt=1; current period must finish as R=4.
    run_cycles("mid_a", 2, 32'b11, 32'b00, 32'b11, 32'b00);
    bus.div_i = 8'h25;
    run_cycles("mid_b", 9, 32'b001110001, 32'b010000010,
                           32'b011011011, 32'b100100100);

    // Phase sync with ch0 at cnt=0 and ch1 at cnt=1; ticks then coincide every 12.
    bus.div_i  = 8'h23;
    bus.sync_i = 1'b1;
    run_cycles("sync", 1, 32'b1, 32'b0, 32'b1, 32'b0);
    bus.sync_i = 1'b0;
    run_cycles("sync_run", 23, 32'h4CCCCC, 32'h111111, 32'h5B6DB6, 32'h249249);

    // Edge ratios: ch0 R=1, ch1 R=16.
    bus.en_i  = 2'b00;
    bus.div_i = 8'hF0;
    step();
    check("dis clk", 32'(bus.clk_o), 32'd0);
    check("dis tick", 32'(bus.tick_o), 32'd0);
    bus.en_i = 2'b11;
    run_cycles("edge", 32, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFF00FF00, 32'h00010001);

    // Disable ch0 at cnt=2, then re-enable from cnt=0.
    bus.en_i  = 2'b00;
    bus.div_i = 8'h23;
    step();
    bus.en_i = 2'b11;
    run_cycles("pre_dis", 3, 32'b110, 32'b000, 32'b110, 32'b001);
    bus.en_i = 2'b10;
    run_cycles("dis0", 1, 32'b0, 32'b0, 32'b1, 32'b0);
    bus.en_i = 2'b11;
    run_cycles("reen", 4, 32'b1100, 32'b0001, 32'b1011, 32'b0100);

    // Async reset between edges must clear outputs without waiting for a clock.
    check("pre_rst clk", 32'(bus.clk_o), 32'h2);
    check("pre_rst tick", 32'(bus.tick_o), 32'h1);
    #2;
    rst = 1'b1;
    #1;
    check("rst_mid clk", 32'(bus.clk_o), 32'd0);
    check("rst_mid tick", 32'(bus.tick_o), 32'd0);
    step();
    check("rst_hold clk", 32'(bus.clk_o), 32'd0);
    rst = 1'b0;
    run_cycles("post_rst", 4, 32'b1100, 32'b0001, 32'b1101, 32'b0010);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
